// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR generator and checker, so both ends
// always use the same polynomial.
package lfsr_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] TAP_MASK = 8'hB8;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        VERIFY  = 2'd1,
        LOCKED  = 2'd2
    } chk_state_t;

    // Feedback is the XOR of the tapped bits, shifted in at the LSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & TAP_MASK)};
    endfunction

endpackage

// File: rtl/lfsr_period_meter.sv
// Measures the LFSR sequence length while locked: counts samples since the
// reference word and latches the count when the reference word comes back.
module lfsr_period_meter
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              start,
    input  logic              sample,
    input  logic              matched,
    input  logic [LFSR_W-1:0] data,
    output logic [8:0]        period,
    output logic              period_valid
);

    logic [LFSR_W-1:0] ref_reg;
    logic [8:0]        per_cnt_reg;
    logic [8:0]        per_cnt_inc;
    logic [8:0]        period_reg;
    logic              period_valid_reg;

    assign per_cnt_inc = (per_cnt_reg == 9'h1FF) ? per_cnt_reg : per_cnt_reg + 9'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_reg          <= '0;
            per_cnt_reg      <= '0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
        end else begin
            if (start) begin
                ref_reg     <= data;
                per_cnt_reg <= '0;
            end else if (sample) begin
                per_cnt_reg <= per_cnt_inc;
                if (matched && (data == ref_reg) && !period_valid_reg && !clear) begin
                    period_reg       <= per_cnt_inc;
                    period_valid_reg <= 1'b1;
                end
            end
            // Losing lock invalidates the measurement but keeps the last value.
            if (clear)
                period_valid_reg <= 1'b0;
        end
    end

    assign period       = period_reg;
    assign period_valid = period_valid_reg;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising receiver for the 8-bit LFSR stream: acquires, verifies,
// then flywheels a local copy and reports mismatches, zero words and period.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [LFSR_W-1:0] shift_seed,
    output logic              locked,
    output logic              err_pulse,
    output logic [15:0]       err_count,
    output logic [8:0]        period,
    output logic              period_valid,
    output logic              zero_seen
);

    localparam logic [3:0] LOCK_CNT4 = LOCK_COUNT[3:0];
    localparam logic [3:0] ERR_LIM4  = ERR_LIMIT[3:0];

    chk_state_t        state_reg, state_next;
    logic [LFSR_W-1:0] pred_reg, pred_next;
    logic [3:0]        match_cnt_reg, match_cnt_next;
    logic [3:0]        miss_cnt_reg, miss_cnt_next;
    logic              err_pulse_reg;
    logic [15:0]       err_count_reg;
    logic              zero_seen_reg;

    logic              sample_match;
    logic              seed_zero;
    logic              err_hit;
    logic              meter_start;
    logic              meter_clear;
    logic              meter_sample;

    assign sample_match = (shift_seed == pred_reg);
    assign seed_zero    = (shift_seed == '0);

    always_comb begin
        state_next     = state_reg;
        pred_next      = pred_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        err_hit        = 1'b0;
        meter_start    = 1'b0;
        meter_clear    = 1'b0;
        meter_sample   = 1'b0;
        if (valid) begin
            case (state_reg)
                ACQUIRE: begin
                    if (!seed_zero) begin
                        pred_next      = lfsr_next(shift_seed);
                        match_cnt_next = '0;
                        state_next     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (sample_match && !seed_zero) begin
                        match_cnt_next = match_cnt_reg + 4'd1;
                        pred_next      = lfsr_next(shift_seed);
                        if (match_cnt_reg + 4'd1 == LOCK_CNT4) begin
                            state_next    = LOCKED;
                            miss_cnt_next = '0;
                            meter_start   = 1'b1;
                        end
                    end else begin
                        state_next = ACQUIRE;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction never reloads from the input.
                    pred_next    = lfsr_next(pred_reg);
                    meter_sample = 1'b1;
                    if (sample_match) begin
                        miss_cnt_next = '0;
                    end else begin
                        err_hit       = 1'b1;
                        miss_cnt_next = miss_cnt_reg + 4'd1;
                        if (miss_cnt_reg + 4'd1 == ERR_LIM4) begin
                            state_next  = ACQUIRE;
                            meter_clear = 1'b1;
                        end
                    end
                end
                default: state_next = ACQUIRE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ACQUIRE;
            pred_reg      <= '0;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
            zero_seen_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pred_reg      <= pred_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            err_pulse_reg <= err_hit;
            if (err_hit && err_count_reg != 16'hFFFF)
                err_count_reg <= err_count_reg + 16'd1;
            if (valid && seed_zero)
                zero_seen_reg <= 1'b1;
        end
    end

    lfsr_period_meter u_meter (
        .clk          (clk),
        .reset        (reset),
        .clear        (meter_clear),
        .start        (meter_start),
        .sample       (meter_sample),
        .matched      (sample_match),
        .data         (shift_seed),
        .period       (period),
        .period_valid (period_valid)
    );

    assign locked    = (state_reg == LOCKED);
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;
    assign zero_seen = zero_seen_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, period, corruption, zero words,
// gapped valid and asynchronous reset.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  shift_seed = 8'h00;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [8:0]  period;
    logic        period_valid;
    logic        zero_seen;

    int checks = 0;
    int errors = 0;
    int txn = 0;
    logic [7:0] gen;

    always #5 clk = ~clk;

    lfsr_checker #(.LOCK_COUNT(4), .ERR_LIMIT(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid        (valid),
        .shift_seed   (shift_seed),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .period       (period),
        .period_valid (period_valid),
        .zero_seen    (zero_seen)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] nxt(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // One valid sample at the next rising edge; returns 1 time unit after it.
    task automatic put(input logic [7:0] w);
        @(negedge clk);
        valid = 1'b1;
        shift_seed = w;
        @(posedge clk);
        #1;
        valid = 1'b0;
        txn++;
        $display("txn %0d: sample %h locked=%b pulse=%b errs=%0d per=%0d pv=%b zero=%b",
                 txn, w, locked, err_pulse, err_count, period, period_valid, zero_seen);
    endtask

    task automatic put_clean();
        put(gen);
        gen = nxt(gen);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_locked", locked, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_period", period, 0);
        check("rst_pvalid", period_valid, 0);
        check("rst_zero", zero_seen, 0);
        @(negedge clk);
        reset = 1'b1;

        // Zero in ACQUIRE, then zero during VERIFY
        put(8'h00);
        check("zero_acq_locked", locked, 0);
        check("zero_acq_seen", zero_seen, 1);
        gen = 8'h01;
        put_clean();
        put_clean();
        put(8'h00);
        check("zero_ver_locked", locked, 0);

        // Clean stream from 01: locks on the 5th sample only if VERIFY was abandoned
        gen = 8'h01;
        for (int i = 0; i < 5; i++) begin
            put_clean();
            check($sformatf("lock_s%0d", i), locked, (i == 4) ? 1 : 0);
        end
        for (int i = 5; i < 259; i++) put_clean();
        check("pre_period_pvalid", period_valid, 0);
        check("pre_period_errs", err_count, 0);
        put_clean();
        check("period_pvalid", period_valid, 1);
        check("period_val", period, 255);
        check("period_errs", err_count, 0);

        // Single corrupted word
        put(gen ^ 8'h10);
        gen = nxt(gen);
        check("single_pulse", err_pulse, 1);
        check("single_errs", err_count, 1);
        check("single_locked", locked, 1);
        put_clean();
        check("single_pulse_off", err_pulse, 0);
        check("single_still_locked", locked, 1);
        check("single_period", period, 255);
        check("single_pvalid", period_valid, 1);

        // Three consecutive corrupted words
        for (int i = 0; i < 3; i++) begin
            put(gen ^ 8'h10);
            gen = nxt(gen);
            check($sformatf("burst_pulse%0d", i), err_pulse, 1);
            check($sformatf("burst_errs%0d", i), err_count, 2 + i);
            check($sformatf("burst_locked%0d", i), locked, (i == 2) ? 0 : 1);
        end
        check("burst_pvalid", period_valid, 0);
        for (int i = 0; i < 5; i++) begin
            put_clean();
            check($sformatf("relock_s%0d", i), locked, (i == 4) ? 1 : 0);
        end

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_locked", locked, 0);
        check("arst_errs", err_count, 0);
        check("arst_period", period, 0);
        check("arst_pvalid", period_valid, 0);
        check("arst_zero", zero_seen, 0);
        @(negedge clk);
        reset = 1'b1;

        // Gapped valid: one sample per three cycles
        for (int i = 0; i < 5; i++) begin
            put_clean();
            check($sformatf("gap_lock_s%0d", i), locked, (i == 4) ? 1 : 0);
            idle(2);
            check($sformatf("gap_hold_s%0d", i), locked, (i == 4) ? 1 : 0);
        end
        for (int i = 5; i < 259; i++) begin
            put_clean();
            idle(2);
        end
        check("gap_pre_pvalid", period_valid, 0);
        put_clean();
        check("gap_pvalid", period_valid, 1);
        check("gap_period", period, 255);
        idle(2);
        check("gap_period_hold", period, 255);
        put(gen ^ 8'h10);
        gen = nxt(gen);
        check("gap_err_pulse", err_pulse, 1);
        idle(1);
        check("gap_pulse_clear", err_pulse, 0);
        check("gap_errs_hold", err_count, 1);
        check("gap_locked_hold", locked, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receiving end of the 8-bit LFSR stream. It samples the generator output `shift_seed` and self-synchronises a local copy of the same polynomial. Once synchronised, it predicts each next value and reports mismatches, loss of lock, illegal all-zero words and the measured sequence period. It sits downstream of `lfsr`, in the integrity-check path and in the silicon self-test wrapper.

## Interface
- `LOCK_COUNT`, default 4: consecutive matching samples required to declare lock (1..15).
- `ERR_LIMIT`, default 3: consecutive mismatches while locked that drop lock (1..15).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low (0 = reset).
- `valid`  in  1: `shift_seed` holds a new sample this cycle.
- `shift_seed`  in  8: sampled LFSR word.
- `locked`  out  1: checker is in LOCKED.
- `err_pulse`  out  1: one-cycle strobe per mismatch while locked.
- `err_count`  out  16: total locked mismatches, saturating at 16'hFFFF.
- `period`  out  9: measured sequence length.
- `period_valid`  out  1: `period` holds a completed measurement.
- `zero_seen`  out  1: sticky; an all-zero sample was received.

## Operation
- Next-state function: feedback `fb = q[7]^q[5]^q[4]^q[3]`, next state `{q[6:0], fb}`. Examples: 8'h01→8'h02, 8'h80→8'h01.
- When `valid` = 0, all state and outputs hold, except `err_pulse`, which returns to 0.
- States:
  - **ACQUIRE**
    - Nonzero sample: `pred` ← next(sample), `match_cnt` ← 0, go to VERIFY.
    - Zero sample: stay in ACQUIRE.
  - **VERIFY**
    - Sample equals `pred`: `match_cnt`++, `pred` ← next(sample).
    - When `match_cnt` reaches `LOCK_COUNT`: go to LOCKED, `ref` ← sample, `per_cnt` ← 0, `miss_cnt` ← 0.
    - Mismatch or zero sample: go to ACQUIRE. No error is counted.
  - **LOCKED**
    - `pred` always ← next(`pred`) (flywheel; the sample is never reloaded).
    - Match: `miss_cnt` ← 0.
    - Mismatch: `err_pulse` = 1, `err_count`++ (saturating), `miss_cnt`++.
    - When `miss_cnt` reaches `ERR_LIMIT`: go to ACQUIRE, clear `period_valid`.
- Period measurement, LOCKED only:
  - Each valid sample increments `per_cnt`, saturating at 511.
  - A matching sample equal to `ref` with `period_valid` = 0 loads `period` ← incremented count and sets `period_valid`. A maximal sequence gives 255.
  - `period_valid` stays set until lock is lost or reset.
- `zero_seen` sets on any valid zero sample in any state and clears only on reset.
- Simultaneous events: the mismatch that hits `ERR_LIMIT` still pulses `err_pulse` and increments `err_count` on the same edge that drops `locked`.

## Timing
- Reset values: state ACQUIRE; every output 0; `pred`, `ref`, all counters 0.
- All outputs are registered and reflect the sample taken at the preceding edge (latency 1).
- Lock latency with continuous `valid`: sample 0 is taken in ACQUIRE; `locked` rises at the edge that samples sample `LOCK_COUNT`.
- `err_pulse` is exactly one cycle wide per mismatched sample.
- `reset` asserted mid-operation clears everything immediately, with no clock needed; the first sample after release is treated as an ACQUIRE sample.

## Structure
- Shared package `lfsr_pkg`: `LFSR_W = 8`, tap mask `8'hB8`, function `lfsr_next`, state enum `chk_state_t` (ACQUIRE, VERIFY, LOCKED). The generator uses the same package so the polynomials cannot diverge.
- One sub-module, `lfsr_period_meter`: holds `ref`, `per_cnt`, `period` and `period_valid`. It has clear/start/sample inputs driven by the FSM.

## Test plan
- Clean stream: seed 8'h01 with continuous `valid` → `locked` rises at the 5th sample edge; `period` = 255 with `period_valid` after one full cycle; `err_count` stays 0.
- Single corrupted word while locked: XOR one sample with 8'h10 → one `err_pulse`, `err_count` = 1, `locked` stays 1, `period` unchanged.
- Three consecutive corrupted words → `err_count` = 3, `locked` falls on the 3rd, `period_valid` cleared; relock after 5 further clean samples.
- Zero injection: 8'h00 during ACQUIRE → stays in ACQUIRE and `zero_seen` = 1; 8'h00 during VERIFY → returns to ACQUIRE.
- Gapped `valid` (one sample per 3 cycles) → same lock point in samples and `period` = 255; outputs hold during gaps.
- `reset` pulsed low mid-LOCKED, between edges → all outputs 0 asynchronously; normal relock afterwards.
